// File: rtl/xor_pipe_arbiter_if.sv
// Request/result bus shared between the arbiter and its producers/consumer.
// No logic; carries NREQ packed operand lanes and one tagged result lane.
// Backpressure travels on req_ready (to producers) and out_ready (from consumer).
interface xor_pipe_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 8
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_d;
   logic [NREQ*W-1:0] req_g;
   logic [NREQ*W-1:0] req_f;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_e;
   logic [IDW-1:0]    out_id;

   // Producer/consumer side
   modport master (
      output req_valid, req_d, req_g, req_f, out_ready,
      input  req_ready, out_valid, out_e, out_id
   );

   // Arbiter side
   modport slave (
      input  req_valid, req_d, req_g, req_f, out_ready,
      output req_ready, out_valid, out_e, out_id
   );
endinterface

// File: rtl/xor_pipe_arbiter.sv
// Round-robin arbiter feeding a 2-stage pipeline computing e = f ^ (d | g), tagged with requester id.
// Latency: transfer at edge k -> out_valid high after edge k+1; one result per cycle sustained.
// Backpressure: out_ready low stalls stage 2; stage 1 still accepts while empty; flush blocks grants.
module xor_pipe_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   xor_pipe_arbiter_if.slave    bus,
   output logic [1:0]           inflight
);
   localparam int IDW = $clog2(NREQ);

   logic [IDW-1:0] ptr_q, ptr_d;
   logic           s1_valid_q, s1_valid_d;
   logic [W-1:0]   s1_opd_q, s1_opd_d;
   logic [W-1:0]   s1_opg_q, s1_opg_d;
   logic [W-1:0]   s1_opf_q, s1_opf_d;
   logic [IDW-1:0] s1_id_q, s1_id_d;
   logic           out_valid_q, out_valid_d;
   logic [W-1:0]   out_e_q, out_e_d;
   logic [IDW-1:0] out_id_q, out_id_d;

   logic [IDW-1:0] win;
   logic           win_vld;
   int             idx;
   logic           adv1, adv2, xfer;

   // Stage 2 moves when empty or drained; stage 1 moves when empty or stage 2 moves.
   assign adv2 = !out_valid_q || bus.out_ready;
   assign adv1 = !s1_valid_q || adv2;
   // Grant is suppressed during flush and while reset is held.
   assign xfer = win_vld && adv1 && !flush && rst_n;

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      win     = ptr_q;
      win_vld = 1'b0;
      idx     = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!win_vld && bus.req_valid[idx]) begin
            win_vld = 1'b1;
            win     = IDW'(idx);
         end
      end
   end

   // One-hot accept toward the winning requester only.
   always_comb begin
      bus.req_ready = '0;
      if (xfer) begin
         bus.req_ready[win] = 1'b1;
      end
   end

   // Next-state for pointer and both pipeline stages; flush overrides valids only.
   always_comb begin
      ptr_d       = ptr_q;
      s1_valid_d  = s1_valid_q;
      s1_opd_d    = s1_opd_q;
      s1_opg_d    = s1_opg_q;
      s1_opf_d    = s1_opf_q;
      s1_id_d     = s1_id_q;
      out_valid_d = out_valid_q;
      out_e_d     = out_e_q;
      out_id_d    = out_id_q;

      if (xfer) begin
         ptr_d = win;
      end

      if (adv1) begin
         s1_valid_d = xfer;
         s1_opd_d   = bus.req_d[int'(win)*W +: W];
         s1_opg_d   = bus.req_g[int'(win)*W +: W];
         s1_opf_d   = bus.req_f[int'(win)*W +: W];
         s1_id_d    = win;
      end

      if (adv2) begin
         out_valid_d = s1_valid_q;
         out_e_d     = s1_opf_q ^ (s1_opd_q | s1_opg_q);
         out_id_d    = s1_id_q;
      end

      if (flush) begin
         s1_valid_d  = 1'b0;
         out_valid_d = 1'b0;
      end
   end

   // State registers; pointer resets to the last index so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= IDW'(NREQ - 1);
         s1_valid_q  <= 1'b0;
         s1_opd_q    <= '0;
         s1_opg_q    <= '0;
         s1_opf_q    <= '0;
         s1_id_q     <= '0;
         out_valid_q <= 1'b0;
         out_e_q     <= '0;
         out_id_q    <= '0;
      end else begin
         ptr_q       <= ptr_d;
         s1_valid_q  <= s1_valid_d;
         s1_opd_q    <= s1_opd_d;
         s1_opg_q    <= s1_opg_d;
         s1_opf_q    <= s1_opf_d;
         s1_id_q     <= s1_id_d;
         out_valid_q <= out_valid_d;
         out_e_q     <= out_e_d;
         out_id_q    <= out_id_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_e     = out_e_q;
   assign bus.out_id    = out_id_q;
   assign inflight      = {1'b0, s1_valid_q} + {1'b0, out_valid_q};

endmodule

// File: tb/tb_xor_pipe_arbiter.sv
// Testbench for xor_pipe_arbiter: directed table plus randomized traffic against a result-level model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// Model tracks two result slots and the round-robin pointer; results are computed at grant time.
module tb_xor_pipe_arbiter;
   localparam int NREQ = 4;
   localparam int W    = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush_s;
   logic [1:0] inflight;

   xor_pipe_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

   xor_pipe_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush_s),
      .bus      (bus),
      .inflight (inflight)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] rv;
      logic       fl;
      logic       ordy;
      logic [3:0] rdy;
      logic       ov;
      logic [7:0] e;
      logic [1:0] id;
      logic [1:0] inf;
   } vec_t;

   vec_t tbl[$];

   int checks   = 0;
   int failures = 0;

   // stimulus state
   logic [NREQ-1:0] rv;
   logic            fl;
   logic            ordy;
   logic [W-1:0]    opd[NREQ];
   logic [W-1:0]    opg[NREQ];
   logic [W-1:0]    opf[NREQ];
   bit   [NREQ-1:0] pend;

   // model state
   int           m_ptr;
   bit           m_s1_v, m_out_v;
   logic [W-1:0] m_s1_e, m_out_e;
   int           m_s1_id, m_out_id;
   bit           m_xfer;
   int           m_win;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(logic [3:0] v, logic f, logic o, logic [3:0] r, logic ov,
                      logic [7:0] e, logic [1:0] id, logic [1:0] inf);
      vec_t x;
      x.rv = v; x.fl = f; x.ordy = o; x.rdy = r; x.ov = ov; x.e = e; x.id = id; x.inf = inf;
      tbl.push_back(x);
   endtask

   function automatic int m_winner(logic [NREQ-1:0] v);
      for (int k = 1; k <= NREQ; k++) begin
         if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] m_ready();
      logic [NREQ-1:0] r;
      int w;
      r = '0;
      w = m_winner(rv);
      if (rst_n && !fl && w >= 0 && !(m_s1_v && m_out_v && !ordy)) r[w] = 1'b1;
      return r;
   endfunction

   task automatic model_reset();
      m_ptr = NREQ - 1;
      m_s1_v = 0; m_out_v = 0;
      m_s1_e = '0; m_out_e = '0;
      m_s1_id = 0; m_out_id = 0;
      m_xfer = 0; m_win = 0;
   endtask

   task automatic model_update();
      logic [NREQ-1:0] r;
      int  w;
      bit  a1, a2;
      m_xfer = 0;
      if (!rst_n) begin
         model_reset();
         return;
      end
      r  = m_ready();
      w  = m_winner(rv);
      a2 = !m_out_v || ordy;
      a1 = !m_s1_v || a2;
      if (fl) begin
         m_s1_v  = 0;
         m_out_v = 0;
      end else begin
         if (a2) begin
            m_out_v  = m_s1_v;
            m_out_e  = m_s1_e;
            m_out_id = m_s1_id;
         end
         if (a1) begin
            m_s1_v = (r != '0);
            if (r != '0) begin
               m_s1_e  = opf[w] ^ (opd[w] | opg[w]);
               m_s1_id = w;
            end
         end
      end
      if (r != '0) begin
         m_ptr  = w;
         m_xfer = 1;
         m_win  = w;
      end
   endtask

   task automatic drive();
      bus.req_valid = rv;
      bus.out_ready = ordy;
      flush_s       = fl;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_d[i*W +: W] = opd[i];
         bus.req_g[i*W +: W] = opg[i];
         bus.req_f[i*W +: W] = opf[i];
      end
   endtask

   task automatic tick(bit use_v, vec_t v);
      drive();
      @(negedge clk);
      chk("req_ready", 32'(bus.req_ready), 32'(m_ready()));
      chk("out_valid", 32'(bus.out_valid), 32'(m_out_v));
      chk("inflight", 32'(inflight), 32'(int'(m_s1_v) + int'(m_out_v)));
      if (m_out_v) begin
         chk("out_e", 32'(bus.out_e), 32'(m_out_e));
         chk("out_id", 32'(bus.out_id), 32'(m_out_id));
      end
      if (!rst_n) begin
         chk("rst_out_e", 32'(bus.out_e), 32'h0);
         chk("rst_out_id", 32'(bus.out_id), 32'h0);
      end
      if (use_v) begin
         chk("tbl_req_ready", 32'(bus.req_ready), 32'(v.rdy));
         chk("tbl_out_valid", 32'(bus.out_valid), 32'(v.ov));
         chk("tbl_inflight", 32'(inflight), 32'(v.inf));
         if (v.ov) begin
            chk("tbl_out_e", 32'(bus.out_e), 32'(v.e));
            chk("tbl_out_id", 32'(bus.out_id), 32'(v.id));
         end
      end
      @(posedge clk);
      model_update();
      #1;
   endtask

   initial begin
      vec_t none;
      none = '{default: '0};

      // directed vectors: d={00,01,0F,03}, g=30, f=FF -> e = {CF,CE,C0,CC}
      add(4'b0100, 0, 1, 4'b0100, 0, 8'h00, 0, 0); // single requester 2
      add(4'b0000, 0, 1, 4'b0000, 0, 8'h00, 0, 1);
      add(4'b0000, 0, 1, 4'b0000, 1, 8'hC0, 2, 1);
      add(4'b0000, 0, 1, 4'b0000, 0, 8'h00, 0, 0);
      add(4'b1111, 0, 1, 4'b1000, 0, 8'h00, 0, 0); // fairness: 3,0,1,2
      add(4'b1111, 0, 1, 4'b0001, 0, 8'h00, 0, 1);
      add(4'b1111, 0, 1, 4'b0010, 1, 8'hCC, 3, 2);
      add(4'b1111, 0, 1, 4'b0100, 1, 8'hCF, 0, 2);
      add(4'b1111, 0, 0, 4'b0000, 1, 8'hCE, 1, 2); // full stall
      add(4'b1111, 0, 0, 4'b0000, 1, 8'hCE, 1, 2);
      add(4'b1111, 0, 0, 4'b0000, 1, 8'hCE, 1, 2);
      add(4'b1111, 0, 1, 4'b1000, 1, 8'hCE, 1, 2); // release, ptr unchanged
      add(4'b0000, 0, 1, 4'b0000, 1, 8'hC0, 2, 2);
      add(4'b0000, 0, 0, 4'b0000, 1, 8'hCC, 3, 1);
      add(4'b0001, 0, 0, 4'b0001, 1, 8'hCC, 3, 1); // partial stall accepts one
      add(4'b0010, 0, 0, 4'b0000, 1, 8'hCC, 3, 2);
      add(4'b0010, 1, 0, 4'b0000, 1, 8'hCC, 3, 2); // flush
      add(4'b0010, 0, 1, 4'b0010, 0, 8'h00, 0, 0);
      add(4'b0000, 0, 1, 4'b0000, 0, 8'h00, 0, 1);
      add(4'b0000, 0, 1, 4'b0000, 1, 8'hCE, 1, 1);
      add(4'b0000, 0, 1, 4'b0000, 0, 8'h00, 0, 0);

      rst_n = 1'b0;
      rv = '1; fl = 1'b0; ordy = 1'b1;
      opd = '{8'h00, 8'h01, 8'h0F, 8'h03};
      opg = '{8'h30, 8'h30, 8'h30, 8'h30};
      opf = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      model_reset();
      drive();
      @(posedge clk); #1;
      repeat (2) tick(0, none);   // reset state with all requests raised
      rst_n = 1'b1;

      foreach (tbl[n]) begin
         rv = tbl[n].rv; fl = tbl[n].fl; ordy = tbl[n].ordy;
         tick(1, tbl[n]);
      end

      // randomized traffic honouring the hold-until-accepted protocol
      rv = '0; fl = 0; pend = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1;
               opd[i] = W'($urandom); opg[i] = W'($urandom); opf[i] = W'($urandom);
            end
         end
         rv   = pend;
         fl   = ($urandom_range(0, 15) == 0);
         ordy = ($urandom_range(0, 3) != 0);
         tick(0, none);
         if (m_xfer) pend[m_win] = 0;
      end

      // fill the pipeline, then drop reset between edges
      rv = '1; fl = 0; ordy = 0;
      repeat (3) tick(0, none);
      chk("pre_reset_inflight", 32'(inflight), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("async_out_valid", 32'(bus.out_valid), 32'd0);
      chk("async_inflight", 32'(inflight), 32'd0);
      chk("async_out_e", 32'(bus.out_e), 32'd0);
      chk("async_req_ready", 32'(bus.req_ready), 32'd0);
      model_reset();
      @(posedge clk); #1;
      tick(0, none);
      rst_n = 1'b1;
      ordy  = 1;
      drive();
      #1;
      chk("post_reset_grant", 32'(bus.req_ready), 32'h1);
      repeat (4) tick(0, none);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
